decoder3_8_pipe: RTL and testbench
==================================

// Module: decoder3_8_pipe
// PURPOSE
//   Registered, handshaked 3-to-8 one-hot decoder; the inverse of the team's 8-to-3 encoder.
//   Accepts binary codes on a valid/ready stream and emits one-hot words downstream.
//   Includes a skid buffer for full throughput under backpressure.
//   Includes a self-scan mode that walks codes 0..7 to produce the walking-one pattern for bring-up.
// PARAMETERS
//   CODE_W     3   code width; OUT_W = 1<<CODE_W (localparam, 8 at default)
//   SCAN_LOOP  0   0: scan 0..7 once then return to PASS; 1: wrap 7->0 until scan_stop
// PORTS
//   clk         in   1       clock, all state on rising edge
//   rst         in   1       synchronous, active-high reset
//   in_valid    in   1       input code valid
//   in_ready    out  1       block can accept input this cycle
//   in_code     in   CODE_W  binary code to decode
//   in_en       in   1       0: item decodes to all-zero word
//   scan_start  in   1       pulse: begin self-scan
//   scan_stop   in   1       pulse: end self-scan
//   scan_busy   out  1       1 while state==SCAN
//   out_valid   out  1       output word valid
//   out_ready   in   1       downstream accepts word
//   out_y       out  OUT_W   one-hot word (en ? 1<<code : 0)
//   out_code    out  CODE_W  code carried with out_y
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset: out_valid=0, out_y=0, out_code=0, scan_busy=0, skid empty, state=PASS, scan counter=0.
//     Reset mid-transfer discards all in-flight items; no partial word appears after reset.
//   Item fields: {code, en}. Decode is out_y = en ? (1<<code) : 0; out_y is never multi-hot.
//   Pipeline: output register plus one skid register.
//     Item accepted in cycle N is visible on out_valid/out_y at N+1 if the output register was free or drained.
//     Output is stable while out_valid && !out_ready.
//   in_ready = (state==PASS) && !skid_valid; driven from registers only.
//     When out_valid && !out_ready, one accepted item goes to skid; in_ready drops the next cycle.
//     When the output drains, the skid item moves to the output register in the same edge.
//     Order is strictly FIFO; one transfer per cycle sustained when out_ready=1.
//   States:
//     PASS -> SCAN when scan_start && !in_valid && !skid_valid && !out_valid.
//       scan_start is ignored otherwise; no pending flag is kept.
//     SCAN: internal source presents {counter, en=1}; in_ready=0 (external input blocked).
//       Counter advances on each internal acceptance (same skid rules).
//       After code 7 is accepted: SCAN_LOOP=0 -> PASS with counter=0; SCAN_LOOP=1 -> counter wraps to 0.
//       scan_stop in SCAN: no further codes are generated; next state is PASS; counter=0.
//       Items already in the pipeline drain normally.
//       scan_stop in PASS is ignored.
//       scan_start and scan_stop together in SCAN: scan_stop wins.
//   scan_busy is 1 exactly while state==SCAN.
// TESTING
//   Codes 0..7, en=1, out_ready=1 -> out_y 01,02,04,..,80 one cycle after each accept; no bubbles.
//   in_code=5, in_en=0 -> out_y=00, out_code=5, out_valid=1.
//   out_ready=0 for 3 cycles while sending 2,3,4 -> 2 held on out_y; 3 in skid; in_ready=0; 4 waits.
//     After release: 2,3,4 delivered in order.
//   scan_start when idle, SCAN_LOOP=0 -> out_y 01..80 in order, then scan_busy=0.
//   SCAN_LOOP=1 -> 80 followed by 01; scan_stop after 02 -> at most one more word, then PASS and in_ready=1.
//   rst asserted with out_valid=1 and skid full -> next cycle out_valid=0, in_ready=1, scan_busy=0.

Source files
------------

// File: rtl/decoder3_8_pipe.sv
// decoder3_8_pipe: registered, handshaked binary-to-one-hot decoder with a
// one-entry skid buffer and a self-scan mode that walks every code once
// (or continuously) to produce a walking-one pattern for board bring-up.
module decoder3_8_pipe #(
  parameter int CODE_W    = 3,
  parameter bit SCAN_LOOP = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CODE_W-1:0]        in_code,
  input  logic                     in_en,
  input  logic                     scan_start,
  input  logic                     scan_stop,
  output logic                     scan_busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1<<CODE_W)-1:0]   out_y,
  output logic [CODE_W-1:0]        out_code
);

  localparam int OUT_W = 1 << CODE_W;

  typedef enum logic {PASS, SCAN} state_t;

  state_t            state;
  state_t            state_next;
  logic [CODE_W-1:0] scan_cnt;
  logic [CODE_W-1:0] scan_cnt_next;

  logic              skid_valid;
  logic [OUT_W-1:0]  skid_y;
  logic [CODE_W-1:0] skid_code;

  logic              src_valid;
  logic [CODE_W-1:0] src_code;
  logic              src_en;
  logic [OUT_W-1:0]  src_y;
  logic              accept;
  logic              out_free;

  // External input is only accepted in PASS with an empty skid; both are
  // registers, so in_ready carries no combinational path from out_ready.
  assign in_ready  = (state == PASS) && !skid_valid;
  assign scan_busy = (state == SCAN);

  // Select the item source (external port or scan counter) and decode it.
  // A scan_stop cycle generates nothing, so the stop takes effect at once.
  always_comb begin
    src_valid = 1'b0;
    src_code  = in_code;
    src_en    = in_en;
    if (state == PASS) begin
      src_valid = in_valid;
    end else begin
      src_valid = !scan_stop;
      src_code  = scan_cnt;
      src_en    = 1'b1;
    end
    accept   = src_valid && !skid_valid;
    out_free = !out_valid || out_ready;
    src_y    = src_en ? (OUT_W'(1) << src_code) : '0;
  end

  // Next-state logic for the PASS/SCAN mode machine and the scan counter.
  // Entry to SCAN requires a fully empty pipeline so scan words never
  // interleave with external items; a refused scan_start is simply dropped.
  always_comb begin
    state_next    = state;
    scan_cnt_next = scan_cnt;
    case (state)
      PASS: begin
        if (scan_start && !in_valid && !skid_valid && !out_valid) begin
          state_next    = SCAN;
          scan_cnt_next = '0;
        end
      end
      SCAN: begin
        if (scan_stop) begin
          state_next    = PASS;
          scan_cnt_next = '0;
        end else if (accept) begin
          scan_cnt_next = scan_cnt + CODE_W'(1);
          if (scan_cnt == '1 && !SCAN_LOOP) begin
            state_next = PASS;
          end
        end
      end
      default: begin
        state_next    = PASS;
        scan_cnt_next = '0;
      end
    endcase
  end

  // Mode and scan counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PASS;
      scan_cnt <= '0;
    end else begin
      state    <= state_next;
      scan_cnt <= scan_cnt_next;
    end
  end

  // Output register plus skid: when the output can move, it takes the skid
  // item first (FIFO order), otherwise the newly accepted item; when it is
  // stalled, a newly accepted item parks in the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_code   <= '0;
      skid_valid <= 1'b0;
      skid_y     <= '0;
      skid_code  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_y      <= skid_y;
        out_code   <= skid_code;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_y     <= src_y;
        out_code  <= src_code;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_y     <= src_y;
      skid_code  <= src_code;
    end
  end

endmodule

// File: tb/tb_decoder3_8_pipe.sv
// Directed bench for decoder3_8_pipe: one instance per scan mode, driven by
// the same stimulus; each step checks against hand-computed values.
module tb_decoder3_8_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_en;
  logic       scan_start;
  logic       scan_stop;
  logic       out_ready;

  logic       in_ready,  scan_busy,  out_valid;
  logic [7:0] out_y;
  logic [2:0] out_code;
  logic       in_ready_l, scan_busy_l, out_valid_l;
  logic [7:0] out_y_l;
  logic [2:0] out_code_l;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [7:0] ONEHOT [8] =
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  decoder3_8_pipe #(.CODE_W(3), .SCAN_LOOP(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_en(in_en), .scan_start(scan_start),
    .scan_stop(scan_stop), .scan_busy(scan_busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_code(out_code)
  );

  decoder3_8_pipe #(.CODE_W(3), .SCAN_LOOP(1'b1)) dut_loop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_code(in_code), .in_en(in_en), .scan_start(scan_start),
    .scan_stop(scan_stop), .scan_busy(scan_busy_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_y(out_y_l), .out_code(out_code_l)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic e);
    in_valid = v;
    in_code  = c;
    in_en    = e;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_en = 1'b0;
    scan_start = 1'b0; scan_stop = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_y",     32'(out_y),     32'h00);
    checkOutput("reset out_code",  32'(out_code),  32'd0);
    checkOutput("reset in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset scan_busy", 32'(scan_busy), 32'd0);

    // Streaming codes 0..7, no backpressure, one word per cycle.
    $display("[TB] streaming codes 0..7");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b1);
      checkOutput($sformatf("stream in_ready %0d", i), 32'(in_ready), 32'd1);
      tick();
      checkOutput($sformatf("stream valid %0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stream y %0d", i),     32'(out_y),     32'(ONEHOT[i]));
      checkOutput($sformatf("stream code %0d", i),  32'(out_code),  32'(i));
    end
    applyStimulus(1'b0, 3'd0, 1'b0);
    tick();
    checkOutput("stream drained", 32'(out_valid), 32'd0);

    // Disabled item decodes to zero but keeps its code.
    applyStimulus(1'b1, 3'd5, 1'b0);
    tick();
    checkOutput("disabled valid", 32'(out_valid), 32'd1);
    checkOutput("disabled y",     32'(out_y),     32'h00);
    checkOutput("disabled code",  32'(out_code),  32'd5);
    applyStimulus(1'b0, 3'd0, 1'b0);
    tick();

    // Backpressure: 2 held on output, 3 in skid, 4 waiting.
    $display("[TB] backpressure 2,3,4");
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd2, 1'b1);
    tick();
    checkOutput("bp y after 2",      32'(out_y),    32'h04);
    checkOutput("bp in_ready skid0", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 3'd3, 1'b1);
    tick();
    checkOutput("bp y held",         32'(out_y),    32'h04);
    checkOutput("bp in_ready skid1", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 3'd4, 1'b1);
    tick();
    checkOutput("bp y still held",   32'(out_y),     32'h04);
    checkOutput("bp code held",      32'(out_code),  32'd2);
    checkOutput("bp valid held",     32'(out_valid), 32'd1);
    checkOutput("bp in_ready still", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("release y 3",      32'(out_y),    32'h08);
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("release y 4",    32'(out_y),    32'h10);
    checkOutput("release code 4", 32'(out_code), 32'd4);
    applyStimulus(1'b0, 3'd0, 1'b0);
    tick();
    checkOutput("release drained", 32'(out_valid), 32'd0);

    // Single-pass scan.
    $display("[TB] scan once");
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    checkOutput("scan busy start", 32'(scan_busy), 32'd1);
    checkOutput("scan in_ready",   32'(in_ready),  32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("scan y %0d", k),    32'(out_y),     32'(ONEHOT[k]));
      checkOutput($sformatf("scan busy %0d", k), 32'(scan_busy), (k == 7) ? 32'd0 : 32'd1);
    end
    tick();
    checkOutput("scan end valid",    32'(out_valid), 32'd0);
    checkOutput("scan end in_ready", 32'(in_ready),  32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Looping scan with stop after the word 02 of the second lap.
    $display("[TB] scan loop");
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("loop y %0d", k), 32'(out_y_l), 32'(ONEHOT[k % 8]));
    end
    scan_stop = 1'b1;
    tick();
    scan_stop = 1'b0;
    checkOutput("loop stop busy",     32'(scan_busy_l), 32'd0);
    checkOutput("loop stop in_ready", 32'(in_ready_l),  32'd1);
    checkOutput("loop stop valid",    32'(out_valid_l), 32'd0);
    tick();

    // Reset with a full pipeline.
    $display("[TB] reset with full skid");
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd6, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("full in_ready", 32'(in_ready),  32'd0);
    checkOutput("full valid",    32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    checkOutput("rst valid",       32'(out_valid),  32'd0);
    checkOutput("rst y",           32'(out_y),      32'h00);
    checkOutput("rst in_ready",    32'(in_ready),   32'd1);
    checkOutput("rst busy",        32'(scan_busy),  32'd0);
    checkOutput("rst loop ready",  32'(in_ready_l), 32'd1);
    tick();
    checkOutput("rst no partial",  32'(out_valid),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
